// File: rtl/reg_bank_writer_pkg.sv
// Shared constants and encodings for the general-purpose register bank write side.
// Used by reg_bank_writer and reg_wr_mode_fmt.
package reg_bank_writer_pkg;

    localparam int REG_WIDTH = 16;
    localparam int REG_NREGS = 16;
    localparam int REG_AW    = 4;

    typedef enum logic [1:0] {
        WM_FULL = 2'b00,
        WM_LUI  = 2'b01,
        WM_LOB  = 2'b10,
        WM_NOP  = 2'b11
    } wr_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    function automatic logic [REG_NREGS-1:0] addr_onehot(input logic [REG_AW-1:0] addr);
        return REG_NREGS'(1) << addr;
    endfunction

endpackage

// File: rtl/reg_wr_mode_fmt.sv
// Combinational write-back formatter: builds the next register value from
// the write mode, the incoming data and the register's current contents.
module reg_wr_mode_fmt
    import reg_bank_writer_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  wr_mode_e           wr_mode,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [WIDTH-1:0]   old_val,
    output logic [WIDTH-1:0]   new_val
);

    always_comb begin
        new_val = old_val;
        case (wr_mode)
            WM_FULL: new_val = wr_data;
            WM_LUI:  new_val = {wr_data[7:0], {(WIDTH-8){1'b0}}};
            WM_LOB:  new_val = {old_val[WIDTH-1:8], wr_data[7:0]};
            default: new_val = old_val;
        endcase
    end

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the 16 x 16-bit register bank: datapath write-back plus a
// one-register-per-cycle clear-all sweep. Optional macro REG_BANK_R0_ZERO_EN hardwires r0 to zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | accepting write-backs; clr_req starts a sweep
// ST_CLEAR | clearing r[cnt] each cycle, writes refused, busy high
module reg_bank_writer
    import reg_bank_writer_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int NREGS = REG_NREGS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [REG_AW-1:0]  wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic [1:0]         wr_mode,
    output logic               wr_ack,
    input  logic               clr_req,
    output logic               busy,
    output logic [WIDTH-1:0]   r0,
    output logic [WIDTH-1:0]   r1,
    output logic [WIDTH-1:0]   r2,
    output logic [WIDTH-1:0]   r3,
    output logic [WIDTH-1:0]   r4,
    output logic [WIDTH-1:0]   r5,
    output logic [WIDTH-1:0]   r6,
    output logic [WIDTH-1:0]   r7,
    output logic [WIDTH-1:0]   r8,
    output logic [WIDTH-1:0]   r9,
    output logic [WIDTH-1:0]   r10,
    output logic [WIDTH-1:0]   r11,
    output logic [WIDTH-1:0]   r12,
    output logic [WIDTH-1:0]   r13,
    output logic [WIDTH-1:0]   r14,
    output logic [WIDTH-1:0]   r15
);

`ifdef REG_BANK_R0_ZERO_EN
    localparam bit R0_HARDWIRED = 1'b1;
`else
    localparam bit R0_HARDWIRED = 1'b0;
`endif

    state_e              state_q, state_d;
    logic [REG_AW-1:0]   cnt_q, cnt_d;
    logic                busy_d;
    logic                clr_en;
    wr_mode_e            mode;

    logic [WIDTH-1:0]    regs [NREGS];
    logic [NREGS-1:0]    wr_sel;
    logic [NREGS-1:0]    clr_sel;
    logic [WIDTH-1:0]    wr_old;
    logic [WIDTH-1:0]    wr_val;

    assign mode = wr_mode_e'(wr_mode);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
        end
    end

    // clr_req is only looked at in IDLE, so a request during a sweep never restarts it
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (clr_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + REG_AW'(1);
                if (cnt_q == REG_AW'(NREGS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        wr_ack = 1'b0;
        clr_en = 1'b0;
        busy_d = 1'b0;
        if (state_q == ST_IDLE) begin
            wr_ack = wr_en && (mode != WM_NOP);
        end else begin
            clr_en = 1'b1;
        end
        if (state_d == ST_CLEAR) begin
            busy_d = 1'b1;
        end
    end

    // writes are only acked in IDLE and clears only happen in CLEAR, so at most one register moves
    assign wr_sel  = wr_ack ? addr_onehot(wr_addr) : '0;
    assign clr_sel = clr_en ? addr_onehot(cnt_q)   : '0;
    assign wr_old  = regs[wr_addr];

    reg_wr_mode_fmt #(
        .WIDTH (WIDTH)
    ) u_fmt (
        .wr_mode (mode),
        .wr_data (wr_data),
        .old_val (wr_old),
        .new_val (wr_val)
    );

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        if (R0_HARDWIRED && (i == 0)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    q <= '0;
                end else if (clr_sel[i]) begin
                    q <= '0;
                end else if (wr_sel[i]) begin
                    q <= wr_val;
                end
            end
            assign regs[i] = q;
        end
    end

    assign r0  = regs[0];
    assign r1  = regs[1];
    assign r2  = regs[2];
    assign r3  = regs[3];
    assign r4  = regs[4];
    assign r5  = regs[5];
    assign r6  = regs[6];
    assign r7  = regs[7];
    assign r8  = regs[8];
    assign r9  = regs[9];
    assign r10 = regs[10];
    assign r11 = regs[11];
    assign r12 = regs[12];
    assign r13 = regs[13];
    assign r14 = regs[14];
    assign r15 = regs[15];

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed self-checking bench for reg_bank_writer (honours REG_BANK_R0_ZERO_EN).
module tb_reg_bank_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_mode;
    logic        wr_ack;
    logic        clr_req;
    logic        busy;
    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;

    logic [15:0] rv    [16];
    logic [15:0] exp_r [16];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_bank_writer dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mode(wr_mode),
        .wr_ack(wr_ack), .clr_req(clr_req), .busy(busy),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15)
    );

    assign rv[0]  = r0;   assign rv[1]  = r1;   assign rv[2]  = r2;   assign rv[3]  = r3;
    assign rv[4]  = r4;   assign rv[5]  = r5;   assign rv[6]  = r6;   assign rv[7]  = r7;
    assign rv[8]  = r8;   assign rv[9]  = r9;   assign rv[10] = r10;  assign rv[11] = r11;
    assign rv[12] = r12;  assign rv[13] = r13;  assign rv[14] = r14;  assign rv[15] = r15;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // r0 reads as zero whatever is written when the hardwired option is built
    function automatic logic [15:0] r0_model(input logic [15:0] v);
`ifdef REG_BANK_R0_ZERO_EN
        return 16'h0000;
`else
        return v;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mode = 2'b00; clr_req = 1'b0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            exp_r[i] = 16'h0000;
            n_cmp++;
            if (rv[i] !== exp_r[i]) begin
                n_err++; $display("FAIL reset_init r%0d: got %h want %h", i, rv[i], exp_r[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_init busy: got %b want 0", busy); end
        reset = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444; wr_mode = 2'b00;
        tick();
        wr_addr = 4'd11; wr_data = 16'hBBBB;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (r4 !== 16'h4444) begin n_err++; $display("FAIL reset_prewrite r4: got %h want 4444", r4); end
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rv[i] !== 16'h0000) begin
                n_err++; $display("FAIL reset_after_write r%0d: got %h want 0000", i, rv[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_after_write busy: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_full_write();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hA5C3; wr_mode = 2'b00;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b1) begin n_err++; $display("FAIL full_ack: got %b want 1", wr_ack); end
        n_cmp++;
        if (r5 !== 16'h0000) begin n_err++; $display("FAIL full_no_bypass r5: got %h want 0000", r5); end
        tick();
        wr_en = 1'b0;
        exp_r[5] = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rv[i] !== exp_r[i]) begin
                n_err++; $display("FAIL full_write r%0d: got %h want %h", i, rv[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_lui_merge();
        wr_en = 1'b1; wr_addr = 4'd9; wr_mode = 2'b01; wr_data = 16'h0012;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b1) begin n_err++; $display("FAIL lui_ack: got %b want 1", wr_ack); end
        tick();
        n_cmp++;
        if (r9 !== 16'h1200) begin n_err++; $display("FAIL lui r9: got %h want 1200", r9); end
        wr_mode = 2'b10; wr_data = 16'h0034;
        tick();
        n_cmp++;
        if (r9 !== 16'h1234) begin n_err++; $display("FAIL merge r9: got %h want 1234", r9); end
        wr_data = 16'hFF56;
        tick();
        n_cmp++;
        if (r9 !== 16'h1256) begin n_err++; $display("FAIL merge_hi_ignored r9: got %h want 1256", r9); end
        wr_mode = 2'b01; wr_addr = 4'd10; wr_data = 16'hAB77;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (r10 !== 16'h7700) begin n_err++; $display("FAIL lui_hi_ignored r10: got %h want 7700", r10); end
        exp_r[9] = 16'h1256; exp_r[10] = 16'h7700;
    endtask

    task automatic test_noop();
        wr_en = 1'b1; wr_addr = 4'd9; wr_mode = 2'b11; wr_data = 16'hFFFF;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b0) begin n_err++; $display("FAIL noop_ack: got %b want 0", wr_ack); end
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rv[i] !== exp_r[i]) begin
                n_err++; $display("FAIL noop_hold r%0d: got %h want %h", i, rv[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_r0();
        wr_en = 1'b1; wr_addr = 4'd0; wr_mode = 2'b00; wr_data = 16'h7777;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b1) begin n_err++; $display("FAIL r0_ack: got %b want 1", wr_ack); end
        tick();
        wr_en = 1'b0;
        exp_r[0] = r0_model(16'h7777);
        n_cmp++;
        if (r0 !== exp_r[0]) begin n_err++; $display("FAIL r0_write: got %h want %h", r0, exp_r[0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) begin
            v = {4{4'(i)}} ^ 16'h5A00;
            wr_en = 1'b1; wr_addr = 4'(i); wr_mode = 2'b00; wr_data = v;
            exp_r[i] = (i == 0) ? r0_model(v) : v;
            #1;
            n_cmp++;
            if (wr_ack !== 1'b1) begin n_err++; $display("FAIL b2b_ack %0d: got %b want 1", i, wr_ack); end
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rv[i] !== exp_r[i]) begin
                n_err++; $display("FAIL b2b r%0d: got %h want %h", i, rv[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_mode = 2'b00; wr_data = 16'hFFFF;
            exp_r[i] = (i == 0) ? r0_model(16'hFFFF) : 16'hFFFF;
            tick();
        end
        wr_en = 1'b0;
        clr_req = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_busy_pre: got %b want 0", busy); end
        tick();
        clr_req = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL sweep_busy_start: got %b want 1", busy); end
        n_cmp++;
        if (r0 !== exp_r[0]) begin n_err++; $display("FAIL sweep_r0_not_yet: got %h want %h", r0, exp_r[0]); end
        for (int k = 1; k <= 16; k++) begin
            if (k == 4) begin
                wr_en = 1'b1; wr_addr = 4'd12; wr_data = 16'h1111; wr_mode = 2'b00;
            end
            if (k == 8) clr_req = 1'b1;
            if (k == 9) clr_req = 1'b0;
            #1;
            if (k >= 4) begin
                n_cmp++;
                if (wr_ack !== 1'b0) begin n_err++; $display("FAIL sweep_blocked_ack k%0d: got %b want 0", k, wr_ack); end
            end
            tick();
            exp_r[k-1] = 16'h0000;
            n_cmp++;
            if (busy !== (k < 16)) begin n_err++; $display("FAIL sweep_busy k%0d: got %b want %b", k, busy, (k < 16)); end
            n_cmp++;
            if (rv[k-1] !== 16'h0000) begin n_err++; $display("FAIL sweep_clear r%0d: got %h want 0000", k-1, rv[k-1]); end
            if (k < 16) begin
                n_cmp++;
                if (rv[k] !== exp_r[k]) begin n_err++; $display("FAIL sweep_order r%0d: got %h want %h", k, rv[k], exp_r[k]); end
            end
        end
        #1;
        n_cmp++;
        if (wr_ack !== 1'b1) begin n_err++; $display("FAIL sweep_held_write_ack: got %b want 1", wr_ack); end
        tick();
        wr_en = 1'b0;
        exp_r[12] = 16'h1111;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL sweep_no_restart busy: got %b want 0", busy); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rv[i] !== exp_r[i]) begin
                n_err++; $display("FAIL sweep_end r%0d: got %h want %h", i, rv[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_simul();
        int n;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; wr_mode = 2'b00; clr_req = 1'b1;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b1) begin n_err++; $display("FAIL simul_ack: got %b want 1", wr_ack); end
        tick();
        wr_en = 1'b0; clr_req = 1'b0;
        n_cmp++;
        if (r3 !== 16'hBEEF) begin n_err++; $display("FAIL simul_written r3: got %h want beef", r3); end
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL simul_busy: got %b want 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != 16) begin n_err++; $display("FAIL simul_sweep_len: got %0d cycles want 16", n); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (rv[i] !== 16'h0000) begin
                n_err++; $display("FAIL simul_end r%0d: got %h want 0000", i, rv[i]);
            end
            exp_r[i] = 16'h0000;
        end
    endtask

    task automatic test_reset_sweep();
        wr_en = 1'b1; wr_addr = 4'd14; wr_data = 16'h2468; wr_mode = 2'b00;
        tick();
        wr_en = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_sweep busy: got %b want 0", busy); end
        n_cmp++;
        if (r14 !== 16'h0000) begin n_err++; $display("FAIL reset_sweep r14: got %h want 0000", r14); end
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'h0F0F; wr_mode = 2'b00;
        #1;
        n_cmp++;
        if (wr_ack !== 1'b1) begin n_err++; $display("FAIL reset_sweep idle_ack: got %b want 1", wr_ack); end
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (r6 !== 16'h0F0F) begin n_err++; $display("FAIL reset_sweep r6: got %h want 0f0f", r6); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_lui_merge();
        test_noop();
        test_r0();
        test_back_to_back();
        test_sweep();
        test_simul();
        test_reset_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
